// File: rtl/riscv_regfile_dbg_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the riscv_regfile_dbg register file slice:
//   - dump_state_e : dump engine FSM encoding (IDLE/SCAN/DONE)
//   - XLEN_DEF, NREGS_DEF : default register width and register count
//   - ZERO_REG : index of the hard-wired zero register (x0)
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/riscv_regfile_dbg_if.sv
// -----------------------------------------------------------------------------
// riscv_regfile_dbg_if
// Debug dump channel of the register file: one (index, value) beat per
// valid/ready handshake plus dump status.
//   dump_start : request a full dump (sampled only while the engine is idle)
//   dump_ready : sink accepts the current beat
//   dump_valid : beat present
//   dump_idx   : register index of the current beat
//   dump_data  : register value of the current beat
//   dump_busy  : dump in progress (SCAN and DONE)
//   dump_done  : one-cycle pulse after the last beat
// Modports: master = register file (beat source), slave = debug sink.
// -----------------------------------------------------------------------------
interface riscv_regfile_dbg_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
);
  localparam int AW = $clog2(NREGS);

  logic            dump_start;
  logic            dump_ready;
  logic            dump_valid;
  logic [AW-1:0]   dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            dump_busy;
  logic            dump_done;

  modport master (
    input  dump_start, dump_ready,
    output dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );

  modport slave (
    output dump_start, dump_ready,
    input  dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );

endinterface

// File: rtl/riscv_regfile_dbg_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
// Dump engine: walks indices 0..NREGS-1 and presents each register as one
// beat on a valid/ready channel. All outputs are registered.
//   clk, rst     : clock, asynchronous active-low reset
//   dump_start   : start request, honoured only in IDLE
//   dump_ready   : sink ready
//   dump_valid/dump_idx/dump_data : current beat
//   dump_busy    : high in SCAN and DONE
//   dump_done    : one-cycle pulse after the last beat
//   next_idx     : index to be loaded on the next handshake (to the array)
//   next_data    : write-first value of regs[next_idx] (from the array)
// -----------------------------------------------------------------------------
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dump_start,
  input  logic            dump_ready,
  output logic            dump_valid,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_busy,
  output logic            dump_done,
  output logic [AW-1:0]   next_idx,
  input  logic [XLEN-1:0] next_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_e state;

  // Wraps to 0 only at LAST_IDX, where it is never used: the terminal
  // index is tested before any increment.
  assign next_idx = dump_idx + AW'(1);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= SCAN;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_idx   <= '0;
            dump_data  <= '0;  // x0 always reads as zero
          end
        end
        SCAN: begin
          if (dump_valid && dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_idx  <= next_idx;
              dump_data <= next_data;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/riscv_regfile_dbg.sv
// -----------------------------------------------------------------------------
// riscv_regfile_dbg
// RISC-V integer register file: NRD combinational read ports, one synchronous
// write port, x0 hard-wired to zero, and a debug dump engine that streams all
// registers over a narrow valid/ready channel.
//   clk, rst : clock, asynchronous active-low reset (clears every register)
//   we, waddr, wdata : write port (writes to x0 are discarded)
//   raddr : NRD flattened read indices, port p at [p*AW +: AW]
//   rdata : NRD flattened read data, port p at [p*XLEN +: XLEN]
//   dump  : debug dump channel (riscv_regfile_dbg_if.master)
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to
// read ports addressing the written register. The dump load is write-first in
// both builds.
// -----------------------------------------------------------------------------
module riscv_regfile_dbg
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  riscv_regfile_dbg_if.master dump
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;
  logic [AW-1:0]   next_idx;
  logic [XLEN-1:0] next_data;

  assign wr_en = we && (waddr != ZERO_IDX);

  // NOTE: the array is reset because the architectural state after reset
  // must read as all zeros, and the dump may run before any write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // NOTE: rdata gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    for (int p = 0; p < NRD; p++) begin
      if (raddr[p*AW +: AW] == ZERO_IDX) begin
        rdata[p*XLEN +: XLEN] = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_en && (raddr[p*AW +: AW] == waddr)) begin
        rdata[p*XLEN +: XLEN] = wdata;
      end
`endif
      else begin
        rdata[p*XLEN +: XLEN] = regs[raddr[p*AW +: AW]];
      end
    end
  end

  // Write-first view of the register the dump loads next, so a write landing
  // on the same edge as the load is captured.
  assign next_data = (wr_en && (waddr == next_idx)) ? wdata : regs[next_idx];

  regfile_dump_fsm #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_dump_fsm (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump.dump_start),
    .dump_ready (dump.dump_ready),
    .dump_valid (dump.dump_valid),
    .dump_idx   (dump.dump_idx),
    .dump_data  (dump.dump_data),
    .dump_busy  (dump.dump_busy),
    .dump_done  (dump.dump_done),
    .next_idx   (next_idx),
    .next_data  (next_data)
  );

endmodule

// File: tb/tb_riscv_regfile_dbg.sv
// -----------------------------------------------------------------------------
// tb_riscv_regfile_dbg
// Self-checking bench for riscv_regfile_dbg. A reference model tracks the
// architectural registers as a plain array and the dump as "which index is
// being presented"; each presented beat is pushed to a queue and a negedge
// monitor compares DUT beats, status and read ports against it.
// Honours REGFILE_BYPASS_EN for the read-port expectation.
// -----------------------------------------------------------------------------
module tb_riscv_regfile_dbg;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                we = 1'b0;
  logic [AW-1:0]       waddr = '0;
  logic [XLEN-1:0]     wdata = '0;
  logic [NRD*AW-1:0]   raddr = '0;
  logic [NRD*XLEN-1:0] rdata;

  riscv_regfile_dbg_if #(.XLEN(XLEN), .NREGS(NREGS)) dif ();

  riscv_regfile_dbg #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata),
    .dump  (dif)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int              idx;
    logic [XLEN-1:0] data;
  } beat_t;

  beat_t           exp_q [$];
  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] seen_data [NREGS];
  bit              m_valid = 0, m_busy = 0, m_done = 0;
  int              m_cur = 0;
  int              n_beats = 0, n_done = 0;

  // Registers change at the edge; a beat loaded at an edge sees that edge's write.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (mem[i]) mem[i] = '0;
      m_valid = 0; m_busy = 0; m_done = 0; m_cur = 0;
      exp_q.delete();
    end else begin
      if (we && waddr != 0) mem[waddr] = wdata;
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_valid) begin
        if (dif.dump_ready) begin
          if (m_cur == NREGS - 1) begin
            m_valid = 0;
            m_done  = 1;
          end else begin
            m_cur++;
            exp_q.push_back(beat_t'{m_cur, mem[m_cur]});
          end
        end
      end else if (dif.dump_start) begin
        m_valid = 1;
        m_busy  = 1;
        m_cur   = 0;
        exp_q.push_back(beat_t'{0, mem[0]});
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input int p);
    int a;
    a = int'(raddr[p*AW +: AW]);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && int'(waddr) == a) return wdata;
`endif
    return mem[a];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    check("dump_valid", 64'(dif.dump_valid), 64'(m_valid));
    check("dump_busy",  64'(dif.dump_busy),  64'(m_busy));
    check("dump_done",  64'(dif.dump_done),  64'(m_done));
    if (dif.dump_done) n_done++;
    if (!rst) begin
      check("rst_dump_idx",  64'(dif.dump_idx),  0);
      check("rst_dump_data", 64'(dif.dump_data), 0);
    end
    if (dif.dump_valid && m_valid) begin
      if (exp_q.size() == 0) begin
        check("beat_queued", 64'(exp_q.size()), 1);
      end else begin
        check("dump_idx",  64'(dif.dump_idx),  64'(exp_q[0].idx));
        check("dump_data", 64'(dif.dump_data), 64'(exp_q[0].data));
        if (dif.dump_ready) begin
          seen_data[exp_q[0].idx] = dif.dump_data;
          void'(exp_q.pop_front());
          n_beats++;
        end
      end
    end
    for (int p = 0; p < NRD; p++)
      check("rdata", 64'(rdata[p*XLEN +: XLEN]), 64'(exp_rd(p)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_raddr();
    for (int p = 0; p < NRD; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
  endtask

  // Pulses dump_start for one edge, then runs until dump_done is seen.
  task automatic run_dump(input bit rnd_ready, input bit wr, input bit poke, input bit x20,
                          output int edges, output bit got);
    dif.dump_start = 1'b1;
    dif.dump_ready = 1'b1;
    we = 1'b0;
    rand_raddr();
    tick();
    dif.dump_start = 1'b0;
    edges = 0;
    got   = 0;
    for (int g = 0; g < 3000 && !got; g++) begin
      rand_raddr();
      dif.dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      dif.dump_start = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
      we = 1'b0;
      if (wr) begin
        we    = 1'($urandom_range(0, 1));
        waddr = (m_valid && $urandom_range(0, 2) == 0) ? AW'(m_cur)
                                                       : AW'($urandom_range(0, NREGS - 1));
        wdata = $urandom;
      end
      if (x20 && m_valid && m_cur == 10) begin
        we    = 1'b1;
        waddr = AW'(20);
        wdata = 32'hAAAA_0000;
      end
      tick();
      edges++;
      if (dif.dump_done) got = 1;
    end
    dif.dump_start = 1'b0;
    we = 1'b0;
  endtask

  int edges;
  bit got;
  int done_before;

  initial begin
    dif.dump_start = 1'b0;
    dif.dump_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // x0 is hard-wired to zero
    we = 1'b1; waddr = '0; wdata = 32'hDEAD_BEEF; raddr = '0;
    #2 check("x0_same_cycle", 64'(rdata[XLEN-1:0]), 0);
    tick();
    we = 1'b0;
    #2 check("x0_after_edge", 64'(rdata[2*XLEN-1:XLEN]), 0);
    tick();

    // write/read of x5 in the same cycle
    we = 1'b1; waddr = AW'(5); wdata = 32'h1234_5678;
    raddr[0 +: AW] = AW'(5); raddr[AW +: AW] = AW'(5);
`ifdef REGFILE_BYPASS_EN
    #2 check("x5_same_cycle", 64'(rdata[XLEN-1:0]), 64'(32'h1234_5678));
`else
    #2 check("x5_same_cycle", 64'(rdata[XLEN-1:0]), 0);
`endif
    tick();
    we = 1'b0;
    #2 check("x5_after_edge", 64'(rdata[2*XLEN-1:XLEN]), 64'(32'h1234_5678));
    tick();

    // preload xi = i*3
    for (int i = 1; i < NREGS; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = XLEN'(i * 3);
      rand_raddr();
      tick();
    end
    we = 1'b0;

    // full dump with ready tied high
    n_beats = 0;
    run_dump(0, 0, 0, 0, edges, got);
    check("dump1_done_seen", 64'(got), 1);
    check("dump1_done_edge", 64'(edges), 64'(NREGS));
    check("dump1_beats", 64'(n_beats), 64'(NREGS));
    check("dump1_x0", 64'(seen_data[0]), 0);
    check("dump1_x31", 64'(seen_data[31]), 93);

    // start during DONE is ignored, the next edge accepts it; x20 written at idx 10
    dif.dump_start = 1'b1;
    tick();
    n_beats = 0;
    run_dump(0, 0, 0, 1, edges, got);
    check("dump2_done_seen", 64'(got), 1);
    check("dump2_done_edge", 64'(edges), 64'(NREGS));
    check("dump2_beats", 64'(n_beats), 64'(NREGS));
    check("dump2_x20", 64'(seen_data[20]), 64'(32'hAAAA_0000));
    check("dump2_x21", 64'(seen_data[21]), 63);

    // backpressure, writes to the presented index, start pokes during SCAN
    n_beats = 0;
    run_dump(1, 1, 1, 0, edges, got);
    check("dump3_done_seen", 64'(got), 1);
    check("dump3_beats", 64'(n_beats), 64'(NREGS));
    tick();

    // abort by reset at beat 7
    done_before = n_done;
    dif.dump_start = 1'b1; dif.dump_ready = 1'b1;
    tick();
    dif.dump_start = 1'b0;
    got = 0;
    for (int g = 0; g < 100 && !got; g++) begin
      if (m_valid && m_cur == 7) got = 1;
      else tick();
    end
    check("reached_beat7", 64'(got), 1);
    #2 rst = 1'b0;
    #1;
    check("abort_valid", 64'(dif.dump_valid), 0);
    check("abort_busy",  64'(dif.dump_busy),  0);
    check("abort_idx",   64'(dif.dump_idx),   0);
    check("abort_data",  64'(dif.dump_data),  0);
    check("abort_rdata", 64'(rdata), 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort_no_done", 64'(n_done), 64'(done_before));

    // re-arm after abort
    n_beats = 0;
    run_dump(1, 1, 1, 0, edges, got);
    check("dump4_done_seen", 64'(got), 1);
    check("dump4_beats", 64'(n_beats), 64'(NREGS));

    // idle traffic, then drain check
    for (int i = 0; i < 20; i++) begin
      we = 1'($urandom_range(0, 1));
      waddr = AW'($urandom_range(0, NREGS - 1));
      wdata = $urandom;
      rand_raddr();
      tick();
    end
    we = 1'b0;
    tick();
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_dbg.md
# riscv_regfile_dbg

Parametrised RISC-V integer register file with `NRD` asynchronous read ports, one synchronous write port, and a built-in debug dump engine. The dump engine streams every register as an (index, value) beat over a valid/ready handshake. It replaces the wide per-register debug outputs of the datapath top with a single narrow channel, so the bench or a debug host can read the whole architectural state after any run length. It sits in the decode stage of the datapath, in place of the fixed 32x32 register bank.

## Interface
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of registers; power of two, ≥ 2
- `NRD`, 2, number of read ports
- `AW` (localparam), `$clog2(NREGS)`, index width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `we`  in  1  write enable
- `waddr`  in  AW  write index
- `wdata`  in  XLEN  write data
- `raddr`  in  NRD*AW  flattened read indices; port p occupies bits [p*AW +: AW]
- `rdata`  out  NRD*XLEN  flattened read data; same packing as `raddr`
- `dump_start`  in  1  request a full dump; sampled only in IDLE
- `dump_ready`  in  1  sink accepts the current beat
- `dump_valid`  out  1  beat present
- `dump_idx`  out  AW  index of the current beat
- `dump_data`  out  XLEN  value of the current beat
- `dump_busy`  out  1  high in SCAN and DONE
- `dump_done`  out  1  one-cycle pulse after the last beat

## Operation
- **Register 0:** reads always return 0. Writes to index 0 are discarded.
- **Read ports:** fully combinational and independent. Any number of ports may address the same index.
- **Write:** when `we` is high, `regs[waddr] <= wdata` at the rising edge.
- **FSM states:** IDLE, SCAN, DONE.
  - IDLE with `dump_start`=1 → SCAN. Load `dump_idx`=0 and `dump_data`=0.
  - SCAN: `dump_valid`=1. A handshake occurs when `dump_valid` and `dump_ready` are both high.
    - On a handshake with `dump_idx` < NREGS-1: increment `dump_idx`, and load `dump_data` with the value of the next register as of that same edge. The load is write-first: a same-edge write to that index is captured.
    - On a handshake with `dump_idx` = NREGS-1: go to DONE.
  - DONE: `dump_done`=1 and `dump_valid`=0 for exactly one cycle, then → IDLE.
- `dump_start` asserted in SCAN or DONE is ignored; it is neither queued nor a restart.
- **Stability:** while `dump_valid`=1 and `dump_ready`=0, `dump_idx` and `dump_data` hold. A write to the index currently being presented does not change `dump_data`. Writes to indices not yet presented are reflected when those indices are loaded.
- **Datapath independence:** the dump never stalls or alters datapath reads or writes.
- **Index arithmetic:** `dump_idx` is AW bits wide and never wraps, because the terminal index is checked before incrementing.

## Timing
- **Reset (asynchronous assert):**
  - all registers are 0
  - `dump_valid`=0, `dump_busy`=0, `dump_done`=0
  - `dump_idx`=0, `dump_data`=0
  - FSM in IDLE
- Reset release is synchronous to `clk`.
- **Reset mid-dump:** immediate abort to IDLE. No `dump_done` pulse is produced.
- **Read latency:** 0 cycles (combinational). Write-to-read latency is 1 edge, except as modified by the bypass under Configuration.
- **Dump timing, `dump_start` high at edge T and `dump_ready` tied high:**
  - `dump_valid` is high from T+1 through T+NREGS, one beat per cycle
  - `dump_done` is high in cycle T+NREGS+1
  - a new `dump_start` is accepted at edge T+NREGS+2
- Each cycle with `dump_ready` low adds one cycle to this schedule.
- `dump_busy` is registered, high from T+1 through the `dump_done` cycle.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** read port p returns `wdata` combinationally when `we`=1, `raddr`[p]=`waddr`, and `waddr`≠0. This is write-to-read forwarding in the same cycle.
- **Not defined:** read ports return the stored value; the new value is visible after the edge.
- The dump engine's write-first load behaves the same in both builds.

## Structure
- **Package `regfile_pkg`:**
  - FSM state encoding: IDLE=2'd0, SCAN=2'd1, DONE=2'd2
  - default `XLEN`/`NREGS` constants
  - the zero-register index constant
- **Sub-module `regfile_dump_fsm`:**
  - contains the state register, `dump_idx` counter, handshake logic, and the `dump_busy`/`dump_done` outputs
  - presents `next_idx` to the storage array
  - receives the write-first read value back from the array
- Storage array and read-port mux remain in the top module.

## Test plan
- **Reset and x0:** assert `rst`=0 mid-run. All `rdata`=0 and all dump outputs are 0. Write 0xDEADBEEF to x0 → reads of x0 return 0.
- **Write/read, both builds:** write 0x12345678 to x5 and read x5 in the same cycle.
  - With bypass: 0x12345678 in that cycle.
  - Without bypass: old value, then 0x12345678 after the edge.
- **Full dump, ready high:** preload xi = i*3. Pulse `dump_start` at T → 32 beats (idx 0..31, data 0..93), `dump_done` at T+33.
- **Backpressure:** toggle `dump_ready` 1-0-1 while a write hits the presented index → data holds until accepted. Total of 32 beats with no duplicates or skips.
- **Write during dump:** write 0xAAAA0000 to x20 while idx=10 → beat 20 carries 0xAAAA0000.
- **Abort and re-arm:** assert reset at beat 7 → no `dump_done`, outputs return to 0. A new `dump_start` after release yields a complete 32-beat dump. A `dump_start` pulsed during SCAN is ignored.
